ddr2_host_arbiter: RTL and testbench

//  Shares the 64-bit host port of ddr2_server_controller among NUM_REQ requesters.

---
 rtl/ddr2_host_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_ddr2_host_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_host_arbiter.sv
// Round-robin arbiter sharing the ddr2_server_controller host port among NUM_REQ requesters.
// Write bursts are streamed into the data FIFO before cmd_put; read returns follow an in-order tag FIFO.
module ddr2_host_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 25,
    parameter int unsigned BEAT_UNIT  = 8,
    parameter int unsigned TAG_DEPTH  = 8,
    parameter logic [2:0]  CMD_READ   = 3'b001,
    parameter logic [2:0]  CMD_WRITE  = 3'b010
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [3*NUM_REQ-1:0]          req_cmd,
    input  logic [2*NUM_REQ-1:0]          req_sz,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ack,
    input  logic [64*NUM_REQ-1:0]         wr_data,
    input  logic [NUM_REQ-1:0]            wr_valid,
    output logic [NUM_REQ-1:0]            wr_ready,
    output logic [63:0]                   rd_data,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [2:0]                    CMD,
    output logic [1:0]                    SZ,
    output logic [ADDR_WIDTH-1:0]         ADDR,
    output logic                          cmd_put,
    output logic [63:0]                   DIN,
    output logic                          put_dataFIFO,
    output logic                          FETCHING,
    input  logic [63:0]                   DOUT,
    input  logic [ADDR_WIDTH-1:0]         RADDR,
    input  logic                          VALIDOUT,
    input  logic                          READY,
    input  logic                          NOTFULL
);
    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned PtrW = $clog2(TAG_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StWdata, StIssue} state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        rr_q, rr_d, id_q, id_d;
    logic [2:0]            cmd_q, cmd_d, cmd_out_q, cmd_out_d;
    logic [1:0]            sz_q, sz_d, sz_out_q, sz_out_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_out_q, addr_out_d;
    logic [7:0]            wbeat_q, wbeat_d, rbeat_q, rbeat_d;
    logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdW+1:0]        tag_mem_q [TAG_DEPTH];

    logic [2:0]            cmd_a  [NUM_REQ];
    logic [1:0]            sz_a   [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
    logic [63:0]           wr_a   [NUM_REQ];
    logic [NUM_REQ-1:0]    elig;
    logic                  tag_full, tag_empty, push, pop, grant_vld;
    logic [IdW-1:0]        grant_id, head_id;
    logic [1:0]            head_sz;
    int unsigned           arb_idx;

    function automatic logic [7:0] beats(input logic [1:0] s);
        return 8'((32'(s) + 32'd1) * BEAT_UNIT);
    endfunction

    assign tag_full  = (cnt_q == CntW'(TAG_DEPTH));
    assign tag_empty = (cnt_q == '0);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign cmd_a[g]  = req_cmd[3*g +: 3];
        assign sz_a[g]   = req_sz[2*g +: 2];
        assign addr_a[g] = req_addr[ADDR_WIDTH*g +: ADDR_WIDTH];
        assign wr_a[g]   = wr_data[64*g +: 64];
        // A read cannot be granted while its tag would have nowhere to go.
        assign elig[g]   = req_valid[g] & ~((req_cmd[3*g +: 3] == CMD_READ) & tag_full);
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        arb_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            arb_idx = 32'(rr_q) + k;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            if (!grant_vld && elig[arb_idx[IdW-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = arb_idx[IdW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        id_d         = id_q;
        cmd_d        = cmd_q;
        sz_d         = sz_q;
        addr_d       = addr_q;
        cmd_out_d    = cmd_out_q;
        sz_out_d     = sz_out_q;
        addr_out_d   = addr_out_q;
        wbeat_d      = wbeat_q;
        req_ack      = '0;
        wr_ready     = '0;
        put_dataFIFO = 1'b0;
        DIN          = '0;
        cmd_put      = 1'b0;
        push         = 1'b0;
        CMD          = cmd_out_q;
        SZ           = sz_out_q;
        ADDR         = addr_out_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    id_d    = grant_id;
                    cmd_d   = cmd_a[grant_id];
                    sz_d    = sz_a[grant_id];
                    addr_d  = addr_a[grant_id];
                    wbeat_d = '0;
                    rr_d    = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
                    state_d = (cmd_a[grant_id] == CMD_WRITE) ? StWdata : StIssue;
                end
            end
            StWdata: begin
                wr_ready[id_q] = NOTFULL;
                DIN            = wr_a[id_q];
                put_dataFIFO   = wr_valid[id_q] & NOTFULL;
                if (put_dataFIFO) begin
                    wbeat_d = wbeat_q + 8'd1;
                    if (wbeat_q + 8'd1 == beats(sz_q)) state_d = StIssue;
                end
            end
            StIssue: begin
                CMD  = cmd_q;
                SZ   = sz_q;
                ADDR = addr_q;
                if (READY) begin
                    cmd_put       = 1'b1;
                    req_ack[id_q] = 1'b1;
                    cmd_out_d     = cmd_q;
                    sz_out_d      = sz_q;
                    addr_out_d    = addr_q;
                    push          = (cmd_q == CMD_READ);
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Return path: beats are steered to whichever requester owns the oldest outstanding read.
    assign {head_id, head_sz} = tag_mem_q[rptr_q];
    assign FETCHING           = ~tag_empty;
    assign rd_data            = DOUT;
    assign rd_addr            = RADDR;

    always_comb begin
        rd_valid = '0;
        pop      = 1'b0;
        rbeat_d  = rbeat_q;
        if (VALIDOUT && !tag_empty) begin
            rd_valid[head_id] = 1'b1;
            pop               = (rbeat_q == beats(head_sz) - 8'd1);
            rbeat_d           = pop ? 8'd0 : rbeat_q + 8'd1;
        end
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) tag_mem_q[wptr_q] <= {id_q, sz_q};
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            rr_q       <= '0;
            id_q       <= '0;
            cmd_q      <= '0;
            sz_q       <= '0;
            addr_q     <= '0;
            cmd_out_q  <= '0;
            sz_out_q   <= '0;
            addr_out_q <= '0;
            wbeat_q    <= '0;
            rbeat_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            cmd_q      <= cmd_d;
            sz_q       <= sz_d;
            addr_q     <= addr_d;
            cmd_out_q  <= cmd_out_d;
            sz_out_q   <= sz_out_d;
            addr_out_q <= addr_out_d;
            wbeat_q    <= wbeat_d;
            rbeat_q    <= rbeat_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ddr2_host_arbiter.sv
// Bench for ddr2_host_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_ddr2_host_arbiter;
    localparam int N  = 4;
    localparam int AW = 25;
    localparam int BU = 8;
    localparam int TD = 8;
    localparam logic [2:0] RD = 3'b001;
    localparam logic [2:0] WR = 3'b010;

    logic            CLK = 1'b0;
    logic            RESET_N = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [3*N-1:0]  req_cmd = '0;
    logic [2*N-1:0]  req_sz = '0;
    logic [AW*N-1:0] req_addr = '0;
    logic [N-1:0]    req_ack;
    logic [64*N-1:0] wr_data = '0;
    logic [N-1:0]    wr_valid = '0;
    logic [N-1:0]    wr_ready;
    logic [63:0]     rd_data;
    logic [AW-1:0]   rd_addr;
    logic [N-1:0]    rd_valid;
    logic [2:0]      CMD;
    logic [1:0]      SZ;
    logic [AW-1:0]   ADDR;
    logic            cmd_put, put_dataFIFO, FETCHING;
    logic [63:0]     DIN;
    logic [63:0]     DOUT = '0;
    logic [AW-1:0]   RADDR = '0;
    logic            VALIDOUT = 1'b0, READY = 1'b0, NOTFULL = 1'b0;

    ddr2_host_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .BEAT_UNIT(BU), .TAG_DEPTH(TD),
                        .CMD_READ(RD), .CMD_WRITE(WR)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_sz(req_sz), .req_addr(req_addr), .req_ack(req_ack), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .CMD(CMD), .SZ(SZ), .ADDR(ADDR), .cmd_put(cmd_put), .DIN(DIN),
        .put_dataFIFO(put_dataFIFO), .FETCHING(FETCHING), .DOUT(DOUT), .RADDR(RADDR),
        .VALIDOUT(VALIDOUT), .READY(READY), .NOTFULL(NOTFULL)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int id; int cmd; int sz; int addr; int left; } txn_t;
    typedef struct { int id; int left; } tag_t;

    bit   m_sync = 0, m_busy = 0, m_found, m_push;
    txn_t m_cur;
    tag_t m_tags[$];
    tag_t m_new;
    int   m_rr = 0, m_last_cmd = 0, m_last_sz = 0, m_last_addr = 0, m_tb, m_i;
    logic [N-1:0] e_ack, e_wrr, e_rdv;
    logic [63:0]  e_din;
    logic         e_put, e_cp;
    int           e_cmd, e_sz, e_addr;

    initial forever begin
        @(negedge CLK);
        if (m_sync) begin
            e_ack = '0; e_wrr = '0; e_put = 1'b0; e_din = '0; e_cp = 1'b0;
            e_cmd = m_last_cmd; e_sz = m_last_sz; e_addr = m_last_addr;
            if (m_busy && m_cur.left > 0) begin
                e_wrr[m_cur.id] = NOTFULL;
                e_put = wr_valid[m_cur.id] & NOTFULL;
                e_din = wr_data[64*m_cur.id +: 64];
            end else if (m_busy) begin
                e_cmd = m_cur.cmd; e_sz = m_cur.sz; e_addr = m_cur.addr;
                e_cp = READY;
                e_ack[m_cur.id] = READY;
            end
            e_rdv = '0;
            if (VALIDOUT && m_tags.size() > 0) e_rdv[m_tags[0].id] = 1'b1;
            chk("req_ack", 64'(req_ack), 64'(e_ack));
            chk("wr_ready", 64'(wr_ready), 64'(e_wrr));
            chk("put_dataFIFO", 64'(put_dataFIFO), 64'(e_put));
            chk("DIN", DIN, e_din);
            chk("cmd_put", 64'(cmd_put), 64'(e_cp));
            chk("CMD", 64'(CMD), 64'(e_cmd));
            chk("SZ", 64'(SZ), 64'(e_sz));
            chk("ADDR", 64'(ADDR), 64'(e_addr));
            chk("FETCHING", 64'(FETCHING), 64'(m_tags.size() > 0));
            chk("rd_valid", 64'(rd_valid), 64'(e_rdv));
            chk("rd_data", rd_data, DOUT);
            chk("rd_addr", 64'(rd_addr), 64'(RADDR));
        end
        if (!RESET_N) begin
            m_busy = 0; m_rr = 0; m_last_cmd = 0; m_last_sz = 0; m_last_addr = 0;
            m_tags.delete();
            m_sync = 1;
        end else if (m_sync) begin
            m_tb = m_tags.size();
            m_push = 0;
            if (!m_busy) begin
                m_found = 0;
                for (int k = 0; k < N; k++) begin
                    m_i = (m_rr + k) % N;
                    if (!m_found && req_valid[m_i] &&
                        !(req_cmd[3*m_i +: 3] == RD && m_tb >= TD)) begin
                        m_found     = 1;
                        m_cur.id    = m_i;
                        m_cur.cmd   = int'(req_cmd[3*m_i +: 3]);
                        m_cur.sz    = int'(req_sz[2*m_i +: 2]);
                        m_cur.addr  = int'(req_addr[AW*m_i +: AW]);
                        m_cur.left  = (m_cur.cmd == int'(WR)) ? (m_cur.sz + 1) * BU : 0;
                        m_rr        = (m_i + 1) % N;
                        m_busy      = 1;
                    end
                end
            end else if (m_cur.left > 0) begin
                if (wr_valid[m_cur.id] && NOTFULL) m_cur.left--;
            end else if (READY) begin
                m_last_cmd = m_cur.cmd; m_last_sz = m_cur.sz; m_last_addr = m_cur.addr;
                m_push = (m_cur.cmd == int'(RD));
                m_busy = 0;
            end
            if (VALIDOUT && m_tags.size() > 0) begin
                m_tags[0].left = m_tags[0].left - 1;
                if (m_tags[0].left == 0) void'(m_tags.pop_front());
            end
            if (m_push) begin
                m_new.id = m_cur.id;
                m_new.left = (m_cur.sz + 1) * BU;
                m_tags.push_back(m_new);
            end
        end
    end

    // ---------------- stimulus ----------------
    int ready_mode = 1, nf_mode = 1, vo_mode = 0, wgap = 0;
    bit auto_req = 0, rst_n = 0;
    logic [N-1:0] hold_mask = '0;
    int wseq[N];
    int cyc = 0;
    logic [N-1:0] ack_seen, rdv_seen, wacc;
    logic put_seen, cp_seen;
    logic [63:0] din_seen;
    logic [2:0] cmd_seen;
    logic [1:0] sz_seen;
    int ack_id[$];
    int ack_cyc[$];
    logic [63:0] put_log[$];
    int rd_cnt[N];
    int n_cmdput = 0;
    logic [2:0] cp_cmd[$];
    logic [1:0] cp_sz[$];

    task automatic clear_logs();
        ack_id.delete(); ack_cyc.delete(); put_log.delete(); cp_cmd.delete(); cp_sz.delete();
        n_cmdput = 0;
        for (int i = 0; i < N; i++) rd_cnt[i] = 0;
    endtask

    task automatic step();
        @(negedge CLK);
        ack_seen = req_ack; put_seen = put_dataFIFO; din_seen = DIN; rdv_seen = rd_valid;
        cp_seen = cmd_put; cmd_seen = CMD; sz_seen = SZ; wacc = wr_valid & wr_ready;
        @(posedge CLK);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i]) begin
                ack_id.push_back(i);
                ack_cyc.push_back(cyc);
                if (!hold_mask[i]) req_valid[i] = 1'b0;
            end
            if (rdv_seen[i]) rd_cnt[i]++;
            if (wacc[i]) wseq[i]++;
        end
        if (put_seen) put_log.push_back(din_seen);
        if (cp_seen) begin
            n_cmdput++;
            cp_cmd.push_back(cmd_seen);
            cp_sz.push_back(sz_seen);
        end
        for (int i = 0; i < N; i++) begin
            if (auto_req && !req_valid[i] && ($urandom % 100) < 30) begin
                req_cmd[3*i +: 3] = ($urandom % 3 == 0) ? WR :
                                    (($urandom % 4 == 0) ? 3'($urandom) : RD);
                req_sz[2*i +: 2]   = 2'($urandom);
                req_addr[AW*i +: AW] = AW'($urandom);
                req_valid[i] = 1'b1;
            end
            wr_data[64*i +: 64] = {32'(i), 32'(wseq[i])};
            wr_valid[i] = (($urandom % 100) >= wgap);
        end
        READY    = (ready_mode == 2) ? ($urandom % 4 != 0) : (ready_mode == 1);
        NOTFULL  = (nf_mode == 2) ? ($urandom % 4 != 0) : (nf_mode == 1);
        VALIDOUT = (vo_mode == 2) ? ($urandom % 100 < 40) : (vo_mode == 1);
        DOUT     = {$urandom, $urandom};
        RADDR    = AW'($urandom);
        RESET_N  = rst_n;
    endtask

    task automatic issue_req(input int i, input logic [2:0] c, input logic [1:0] s,
                             input logic [AW-1:0] a);
        req_cmd[3*i +: 3]    = c;
        req_sz[2*i +: 2]     = s;
        req_addr[AW*i +: AW] = a;
        req_valid[i]         = 1'b1;
    endtask

    task automatic do_reset();
        req_valid = '0; hold_mask = '0; auto_req = 0;
        ready_mode = 1; nf_mode = 1; vo_mode = 0; wgap = 0;
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();
        for (int i = 0; i < N; i++) wseq[i] = 0;
        clear_logs();
    endtask

    task automatic wait_ack(input string nm, input int id, input int max);
        bit got = 0;
        for (int c = 0; c < max && !got; c++) begin
            step();
            if (ack_seen[id]) got = 1;
        end
        chk(nm, 64'(got), 64'd1);
    endtask

    function automatic int acks_of(input int id);
        int n = 0;
        foreach (ack_id[k]) if (ack_id[k] == id) n++;
        return n;
    endfunction

    initial begin
        do_reset();
        #2;
        chk("reset_outputs", {req_ack, wr_ready, rd_valid, 3'(CMD), 2'(SZ), cmd_put,
                              put_dataFIFO, FETCHING}, 64'd0);
        chk("reset_addr_din", {DIN[31:0], 7'd0, ADDR}, 64'd0);

        // 1: single read from requester 0, SZ=0 returns 8 beats
        issue_req(0, RD, 2'd0, 25'h100);
        wait_ack("t1_ack", 0, 10);
        chk("t1_cmd", 64'(cp_cmd.size() > 0 ? cp_cmd[0] : 3'd7), 64'h1);
        #2;
        chk("t1_fetching", 64'(FETCHING), 64'd1);
        vo_mode = 1;
        repeat (8) step();
        vo_mode = 0;
        step();
        #2;
        chk("t1_beats", 64'(rd_cnt[0]), 64'd8);
        chk("t1_other_beats", 64'(rd_cnt[1] + rd_cnt[2] + rd_cnt[3]), 64'd0);
        chk("t1_fifo_empty", 64'(FETCHING), 64'd0);
        chk("t1_one_put", 64'(n_cmdput), 64'd1);

        // 2: all four hold reads; grant order and spacing
        do_reset();
        hold_mask = '1;
        for (int i = 0; i < N; i++) issue_req(i, RD, 2'd0, AW'(i * 16));
        for (int c = 0; c < 40 && ack_id.size() < 5; c++) step();
        hold_mask = '0;
        req_valid = '0;
        chk("t2_nacks", 64'(ack_id.size()), 64'd5);
        if (ack_id.size() >= 5) begin
            chk("t2_order", {32'(ack_id[0]), 8'(ack_id[1]), 8'(ack_id[2]), 8'(ack_id[3]),
                             8'(ack_id[4])}, 64'h0000_0000_0001_0203 << 8);
            for (int k = 1; k < 5; k++) chk("t2_spacing", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'd2);
        end
        vo_mode = 1;
        repeat (44) step();
        vo_mode = 0;
        step();
        #2;
        chk("t2_beats_r0", 64'(rd_cnt[0]), 64'd16);
        chk("t2_beats_r3", 64'(rd_cnt[3]), 64'd8);
        chk("t2_drained", 64'(FETCHING), 64'd0);

        // 3: write from requester 2, SZ=1, gappy data, NOTFULL low 3 cycles
        do_reset();
        wgap = 30;
        issue_req(2, WR, 2'd1, 25'h1abc0);
        repeat (4) step();
        nf_mode = 0;
        repeat (3) step();
        nf_mode = 1;
        wait_ack("t3_ack", 2, 200);
        chk("t3_nbeats", 64'(put_log.size()), 64'd16);
        for (int k = 0; k < 16 && k < put_log.size(); k++)
            chk("t3_data", put_log[k], {32'd2, 32'(k)});
        chk("t3_cmd", 64'(cp_cmd.size() > 0 ? cp_cmd[0] : 3'd7), 64'h2);
        chk("t3_sz", 64'(cp_sz.size() > 0 ? cp_sz[0] : 2'd0), 64'd1);
        wgap = 0;

        // 4: tag FIFO full stalls reads but not writes
        do_reset();
        hold_mask[0] = 1'b1;
        issue_req(0, RD, 2'd0, 25'h40);
        repeat (30) step();
        hold_mask = '0;
        chk("t4_eight_reads", 64'(acks_of(0)), 64'd8);
        issue_req(1, WR, 2'd0, 25'h80);
        wait_ack("t4_write_ack", 1, 40);
        chk("t4_read_stalled", 64'(acks_of(0)), 64'd8);
        vo_mode = 1;
        wait_ack("t4_ninth_read", 0, 40);
        repeat (80) step();
        vo_mode = 0;
        step();
        #2;
        chk("t4_drained", 64'(FETCHING), 64'd0);

        // 5: READY held low in issue
        do_reset();
        ready_mode = 0;
        issue_req(3, 3'b100, 2'd2, 25'h5555);
        repeat (12) step();
        chk("t5_held_off", 64'(n_cmdput), 64'd0);
        ready_mode = 1;
        wait_ack("t5_ack", 3, 5);
        repeat (3) step();
        chk("t5_once", 64'(n_cmdput), 64'd1);
        chk("t5_cmd", 64'(cp_cmd.size() > 0 ? cp_cmd[0] : 3'd7), 64'h4);

        // 6: reset in the middle of a write burst
        do_reset();
        issue_req(0, RD, 2'd0, 25'h10);
        wait_ack("t6_read", 0, 10);
        issue_req(1, WR, 2'd3, 25'h20);
        repeat (10) step();
        chk("t6_midburst", 64'(put_log.size() > 0 && put_log.size() < 32), 64'd1);
        req_valid = '0;
        rst_n = 0;
        step();
        rst_n = 1;
        vo_mode = 1;
        step();
        #2;
        chk("t6_zero_ctl", {req_ack, wr_ready, rd_valid, 3'(CMD), 2'(SZ), cmd_put,
                            put_dataFIFO, FETCHING}, 64'd0);
        chk("t6_zero_addr", 64'(ADDR), 64'd0);
        chk("t6_zero_din", DIN, 64'd0);
        chk("t6_no_wr_ack", 64'(acks_of(1)), 64'd0);
        vo_mode = 0;
        for (int i = 0; i < N; i++) wseq[i] = 0;
        clear_logs();
        for (int i = N - 1; i >= 0; i--) issue_req(i, RD, 2'd0, AW'(i));
        for (int c = 0; c < 10 && ack_id.size() == 0; c++) step();
        chk("t6_rr_reset", 64'(ack_id.size() > 0 ? ack_id[0] : 9), 64'd0);

        // Randomized traffic, with a reset in the middle
        do_reset();
        auto_req = 1; ready_mode = 2; nf_mode = 2; vo_mode = 2; wgap = 25;
        repeat (3000) step();
        rst_n = 0;
        step();
        rst_n = 1;
        repeat (2000) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
